// File: rtl/poly94_uart_pkg.sv
// -----------------------------------------------------------------------------
// poly94_uart_pkg
// Shared constants and types for the poly94 UART blocks. The RX FIFO and the
// CSR block both import this package, so they agree on the byte width, the
// FIFO depth and the bit positions of the RX status fields in UART_STATUS.
// Optional feature macro used by uart_rx_fifo: UART_RX_FIFO_DROP_CNT_EN.
// -----------------------------------------------------------------------------
package poly94_uart_pkg;

    localparam int UART_BYTE_W        = 8;
    localparam int UART_RX_FIFO_DEPTH = 16;

    typedef logic [UART_BYTE_W-1:0] uart_byte_t;

    // UART_STATUS field positions shared with the CSR block.
    localparam int CSR_RX_NOT_EMPTY_BIT = 0;
    localparam int CSR_RX_OVERRUN_BIT   = 1;
    localparam int CSR_RX_LEVEL_LSB     = 8;
    localparam int CSR_RX_LEVEL_W       = $clog2(UART_RX_FIFO_DEPTH) + 1;

endpackage : poly94_uart_pkg

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Receive buffer between the UART core's AXI-Stream RX output and the CSR
// block. First-word-fall-through: the head byte is always visible on data_o.
// The UART line cannot be stalled, so s_axis_tready is 1 outside reset and a
// byte arriving while full is dropped and recorded in the sticky overrun flag.
//
// Optional feature: define UART_RX_FIFO_DROP_CNT_EN to get an 8-bit saturating
// dropped-byte counter on drop_cnt_o; otherwise drop_cnt_o is tied to 0.
//
// Ports:
//   clk_i          system clock (clk_sys)
//   rst_i          asynchronous active-high reset
//   s_axis_tdata   byte from UART RX
//   s_axis_tvalid  byte valid
//   s_axis_tready  ready to UART (1 outside reset)
//   pop_i          one-cycle strobe, consumes the head entry
//   flush_i        synchronous flush of all entries
//   data_o         head entry (0 while empty)
//   not_empty_o    head valid
//   full_o         level == DEPTH
//   level_o        current entry count
//   overrun_o      sticky: a byte was dropped
//   overrun_clr_i  clears overrun_o and the drop counter
//   drop_cnt_o     dropped-byte count (0 unless the optional counter is built)
// -----------------------------------------------------------------------------
module uart_rx_fifo
    import poly94_uart_pkg::*;
#(
    parameter int DEPTH = UART_RX_FIFO_DEPTH,
    parameter int WIDTH = UART_BYTE_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [WIDTH-1:0]         s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     not_empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overrun_o,
    input  logic                     overrun_clr_i,
    output logic [7:0]               drop_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [LW-1:0]    r_level;
    logic             r_overrun;
    logic             r_ready;

    logic [LW-1:0]    w_level_nxt;
    logic             w_full;
    logic             w_not_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_wr_en;
    logic             w_drop;

    // Flags come from the level register only, never from inputs.
    assign w_full      = (r_level == LW'(DEPTH));
    assign w_not_empty = (r_level != '0);

    assign w_push = s_axis_tvalid & r_ready;
    assign w_pop  = pop_i & w_not_empty;

    // A pop in the same cycle frees the slot first, so a full FIFO still
    // accepts the byte. A flush discards the byte without counting a drop.
    assign w_wr_en = w_push & ~flush_i & (~w_full | w_pop);
    assign w_drop  = w_push & ~flush_i & w_full & ~w_pop;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path through the block leaves it unassigned and infers a latch.
    always_comb begin
        w_level_nxt = r_level;
        if (w_wr_en && !w_pop) begin
            w_level_nxt = r_level + 1'b1;
        end else if (!w_wr_en && w_pop) begin
            w_level_nxt = r_level - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_level   <= '0;
            r_overrun <= 1'b0;
            r_ready   <= 1'b0;
        end else begin
            r_ready <= 1'b1;
            if (flush_i) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_level  <= '0;
            end else begin
                if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
                r_level <= w_level_nxt;
            end
            // Set wins over clear so a drop in the clear cycle is not lost.
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr_i) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // NOTE: the storage array has no reset; stale entries are never visible
    // because data_o is masked while empty and the pointers are reset.
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= s_axis_tdata;
        end
    end

`ifdef UART_RX_FIFO_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    // Saturating count; a drop in the clear cycle leaves a count of one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_drop_cnt <= '0;
        end else if (w_drop && overrun_clr_i) begin
            r_drop_cnt <= 8'd1;
        end else if (overrun_clr_i) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign drop_cnt_o = r_drop_cnt;
`else
    assign drop_cnt_o = '0;
`endif

    assign s_axis_tready = r_ready;
    assign data_o        = w_not_empty ? r_mem[r_rd_ptr] : '0;
    assign not_empty_o   = w_not_empty;
    assign full_o        = w_full;
    assign level_o       = r_level;
    assign overrun_o     = r_overrun;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
// Directed bench for uart_rx_fifo. Stimulus pushes the bytes it expects the
// FIFO to accept into a scoreboard queue; a monitor compares data_o against
// the queue head on every effective pop. Status outputs are compared against
// hand-computed values at quiet points between stimulus phases.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

`ifdef UART_RX_FIFO_DROP_CNT_EN
    localparam int DC_ON = 1;
`else
    localparam int DC_ON = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] s_axis_tdata = '0;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic       pop_i = 1'b0;
    logic       flush_i = 1'b0;
    logic [7:0] data_o;
    logic       not_empty_o;
    logic       full_o;
    logic [4:0] level_o;
    logic       overrun_o;
    logic       overrun_clr_i = 1'b0;
    logic [7:0] drop_cnt_o;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];

    uart_rx_fifo dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .pop_i         (pop_i),
        .flush_i       (flush_i),
        .data_o        (data_o),
        .not_empty_o   (not_empty_o),
        .full_o        (full_o),
        .level_o       (level_o),
        .overrun_o     (overrun_o),
        .overrun_clr_i (overrun_clr_i),
        .drop_cnt_o    (drop_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every effective pop must present the oldest expected byte.
    always @(negedge clk) begin
        if (!rst_i && pop_i && not_empty_o) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL pop_data: got 0x%0h, expected no data (scoreboard empty)", data_o);
            end else begin
                check("pop_data", 32'(data_o), 32'(exp_q.pop_front()));
            end
        end
    end

    // Apply one cycle of inputs at the next rising edge, then return to idle.
    task automatic step(input logic v, input logic [7:0] d, input logic p,
                        input logic fl, input logic clr);
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        pop_i         = p;
        flush_i       = fl;
        overrun_clr_i = clr;
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        pop_i         = 1'b0;
        flush_i       = 1'b0;
        overrun_clr_i = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] d);
        exp_q.push_back(d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_state(input string tag, input int lvl, input logic ne,
                                input logic fu, input logic ov, input int dc,
                                input logic [7:0] dat);
        @(negedge clk);
        check({tag, "_level"},     32'(level_o),       32'(lvl));
        check({tag, "_not_empty"}, 32'(not_empty_o),   32'(ne));
        check({tag, "_full"},      32'(full_o),        32'(fu));
        check({tag, "_overrun"},   32'(overrun_o),     32'(ov));
        check({tag, "_drop_cnt"},  32'(drop_cnt_o),    32'(dc));
        check({tag, "_data"},      32'(data_o),        32'(dat));
        check({tag, "_tready"},    32'(s_axis_tready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values.
        @(negedge clk);
        check("rst_tready",    32'(s_axis_tready), 32'd0);
        check("rst_level",     32'(level_o),       32'd0);
        check("rst_not_empty", 32'(not_empty_o),   32'd0);
        check("rst_full",      32'(full_o),        32'd0);
        check("rst_overrun",   32'(overrun_o),     32'd0);
        check("rst_drop_cnt",  32'(drop_cnt_o),    32'd0);
        check("rst_data",      32'(data_o),        32'd0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        expect_state("idle", 0, 1'b0, 1'b0, 1'b0, 0, 8'h00);

        // Three consecutive pushes; head visible one cycle after the first.
        exp_q.push_back(8'h41);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'h41;
        @(posedge clk);
        #1;
        exp_q.push_back(8'h42);
        s_axis_tdata = 8'h42;
        @(negedge clk);
        check("fwft_data",      32'(data_o),      32'h41);
        check("fwft_not_empty", 32'(not_empty_o), 32'd1);
        @(posedge clk);
        #1;
        push_exp(8'h43);
        expect_state("t1_fill", 3, 1'b1, 1'b0, 1'b0, 0, 8'h41);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        expect_state("t1_drain", 0, 1'b0, 1'b0, 1'b0, 0, 8'h00);

        // Fill to 16, then the 17th byte is dropped.
        for (int i = 0; i < 16; i++) push_exp(8'(i));
        expect_state("t2_full", 16, 1'b1, 1'b1, 1'b0, 0, 8'h00);
        step(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
        expect_state("t2_drop", 16, 1'b1, 1'b1, 1'b1, DC_ON, 8'h00);

        // Clear together with a drop: set wins, counter restarts at one.
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
        expect_state("t5_clr_drop", 16, 1'b1, 1'b1, 1'b1, DC_ON, 8'h00);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        expect_state("t5_clr", 16, 1'b1, 1'b1, 1'b0, 0, 8'h00);

        // Full: push with pop is accepted, no overrun.
        exp_q.push_back(8'h55);
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        expect_state("t3_full_pp", 16, 1'b1, 1'b1, 1'b0, 0, 8'h01);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        expect_state("t3_drain", 0, 1'b0, 1'b0, 1'b0, 0, 8'h00);
        check("t3_scoreboard_left", 32'(exp_q.size()), 32'd0);

        // Empty: pop alone ignored; push with pop leaves one entry.
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        expect_state("t4_empty_pop", 0, 1'b0, 1'b0, 1'b0, 0, 8'h00);
        exp_q.push_back(8'h7E);
        step(1'b1, 8'h7E, 1'b1, 1'b0, 1'b0);
        expect_state("t4_pp", 1, 1'b1, 1'b0, 1'b0, 0, 8'h7E);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        expect_state("t4_drain", 0, 1'b0, 1'b0, 1'b0, 0, 8'h00);

        // Level 5: flush with a push discards everything.
        for (int i = 1; i <= 5; i++) push_exp(8'(i));
        expect_state("t6_lvl5", 5, 1'b1, 1'b0, 1'b0, 0, 8'h01);
        step(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
        exp_q.delete();
        expect_state("t6_flush", 0, 1'b0, 1'b0, 1'b0, 0, 8'h00);

        // Full with overrun set: flush plus push is neither a drop nor a clear.
        for (int i = 0; i < 16; i++) push_exp(8'h20 + 8'(i));
        step(1'b1, 8'hAB, 1'b0, 1'b0, 1'b0);
        expect_state("t6_ovr", 16, 1'b1, 1'b1, 1'b1, DC_ON, 8'h20);
        step(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
        exp_q.delete();
        expect_state("t6_full_flush", 0, 1'b0, 1'b0, 1'b1, DC_ON, 8'h00);

        // Reset mid-burst with overrun still set: outputs clear before any edge.
        push_exp(8'hC1);
        push_exp(8'hC2);
        push_exp(8'hC3);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'h33;
        rst_i         = 1'b1;
        #2;
        check("arst_level",     32'(level_o),       32'd0);
        check("arst_not_empty", 32'(not_empty_o),   32'd0);
        check("arst_full",      32'(full_o),        32'd0);
        check("arst_overrun",   32'(overrun_o),     32'd0);
        check("arst_drop_cnt",  32'(drop_cnt_o),    32'd0);
        check("arst_tready",    32'(s_axis_tready), 32'd0);
        check("arst_data",      32'(data_o),        32'd0);
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        expect_state("post_rst", 0, 1'b0, 1'b0, 1'b0, 0, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_uart_rx_fifo
